led_fade_player: RTL
====================

Name: led_fade_player

Overview:
- Consumer side of the tick/random generator: takes the slow play strobe and the 8-bit LFSR byte and drives the light-stick LEDs.
- Runs a fade-up / hold / fade-down / gap pattern state machine and PWM-modulates the LEDs at the current brightness.
- Sits between the clock/tick generator and the LED pins. It is the only block that turns ticks and random numbers into visible output.

Parameters:
- N_LED, 8, number of LED outputs (1..8).
- STEP, 16, brightness change per tick_play strobe during fades (1..255).
- HOLD_TICKS, 4, number of tick_play strobes spent at full brightness (1..255).
- PWM_DIV, 1, number of internal_clk cycles per PWM counter increment (1..255).

Ports:
- internal_clk  in  1  system clock. Single clock domain; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick_play  in  1  one-cycle strobe that advances the pattern FSM.
- rand_num  in  8  free-running pseudo-random byte, sampled only where stated.
- start  in  1  one-cycle request to begin the pattern.
- stop  in  1  one-cycle request to end the pattern at the next gap exit.
- mode  in  2  pattern mode: 0 = all LEDs, 1 = random mask, 2 = chase, 3 = treated as 0.
- led  out  N_LED  PWM-modulated LED drive.
- level  out  8  current brightness.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE, level=0, led=0, busy=0, pwm_cnt=0, prescaler=0, stop_pending=0, led_mask=all ones, chase one-hot=bit 0, hold/gap counters=0.
- PWM:
  - 8-bit pwm_cnt increments (wrapping 255->0) once every PWM_DIV clocks.
  - led[i] is registered as (state!=IDLE) && led_mask[i] && (pwm_cnt < level).
  - Output lags the state/level change by 1 clock.
  - level=0 gives fully off; level=255 gives 255/256 duty.
- States (all transitions are registered; FSM moves only on tick_play except start/stop handling in IDLE):
  - IDLE:
    - start=1 and stop=0 -> FADE_UP. level=0, stop_pending cleared, mask captured.
    - start together with stop -> stay in IDLE.
  - FADE_UP:
    - Each tick: level = min(level+STEP, 255), computed 9-bit then saturated.
    - When the new level is 255 -> HOLD with hold_cnt=0.
  - HOLD:
    - Each tick: hold_cnt++.
    - When hold_cnt reaches HOLD_TICKS-1 on a tick -> FADE_DOWN.
    - Total time in HOLD is exactly HOLD_TICKS ticks.
  - FADE_DOWN:
    - Each tick: level = max(level-STEP, 0), saturating.
    - When the new level is 0 -> GAP, with gap_len = rand_num[3:0]+1 sampled on that same clock.
  - GAP:
    - Each tick: gap_cnt++.
    - After gap_len ticks: if stop_pending -> IDLE; else -> FADE_UP with mask recaptured.
- Mask capture (on entry to FADE_UP):
  - mode 0/3: all ones.
  - mode 1: rand_num[N_LED-1:0]. If that value is 0, use all ones.
  - mode 2: chase one-hot rotated left by 1, wrapping the top bit to bit 0. The first entry after reset/IDLE uses bit 0 without rotating.
- mode changes take effect only at the next mask capture.
- stop:
  - In IDLE: ignored.
  - Otherwise: sets stop_pending (sticky until IDLE).
  - Does not shorten the current cycle.
- start while busy: ignored.
- tick_play in IDLE: ignored.
- tick_play held high several clocks: each high clock counts as a tick. Not debounced.
- Simultaneous tick_play and stop in GAP on the final gap tick: stop counts, FSM goes to IDLE.
- busy=0 exactly in IDLE. On entering IDLE, level is forced to 0.
- Reset asserted mid-pattern: all outputs go to reset values immediately (asynchronous), with no glitch on release.

Test Plan:
- Reset, then start with mode=0, STEP=16: level goes 16,32,...,240,255 over 16 ticks; HOLD lasts 4 ticks; FADE_DOWN goes 239,...,15,0 over 16 ticks; busy=1 throughout.
- PWM check with a static level=64, PWM_DIV=1: each led is high for exactly 64 of every 256 clocks; at level=255, high for 255 of 256.
- mode=1, rand_num=0xA5 on the FADE_UP entry clock: only led[0,2,5,7] ever toggle. With rand_num=0x00 at capture, all 8 LEDs toggle.
- mode=2 over 3 full cycles: masks are 0x01, 0x02, 0x04. After 8 cycles the mask wraps back to 0x01.
- rand_num[3:0]=0x6 at GAP entry: GAP lasts 7 ticks. stop pulsed during FADE_UP: the cycle completes, the FSM reaches IDLE after the gap, busy=0, led=0.
- Async reset mid-HOLD: led=0, level=0, busy=0 within the same clock. start together with stop in IDLE: the FSM stays in IDLE.

Source files
------------

// File: rtl/led_fade_player.sv
// LED pattern player: fade-up / hold / fade-down / gap sequencer driving
// PWM-modulated LED outputs at the current brightness level.
module led_fade_player #(
  parameter int N_LED      = 8,
  parameter int STEP       = 16,
  parameter int HOLD_TICKS = 4,
  parameter int PWM_DIV    = 1
) (
  input  logic             internal_clk,
  input  logic             reset,
  input  logic             tick_play,
  input  logic [7:0]       rand_num,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic [7:0]       level,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, FADE_UP, HOLD, FADE_DOWN, GAP} state_t;

  localparam logic [N_LED-1:0] CHASE_FIRST = N_LED'(1);

  state_t           state;
  logic [7:0]       pwm_cnt;
  logic [7:0]       prescaler;
  logic [7:0]       hold_cnt;
  logic [4:0]       gap_len;
  logic [4:0]       gap_cnt;
  logic             stop_pending;
  logic [N_LED-1:0] led_mask;
  logic [N_LED-1:0] chase;

  logic [8:0]       up_sum;
  logic [7:0]       up_level;
  logic [7:0]       down_level;
  logic [N_LED-1:0] rand_mask;
  logic [N_LED-1:0] chase_rot;
  logic             pwm_on;

  always_comb begin
    up_sum     = {1'b0, level} + 9'(STEP);
    up_level   = up_sum[8] ? 8'hFF : up_sum[7:0];
    down_level = (level > 8'(STEP)) ? level - 8'(STEP) : '0;
    rand_mask  = (rand_num[N_LED-1:0] == '0) ? '1 : rand_num[N_LED-1:0];
    // Shift-based rotate stays legal for N_LED == 1 (degenerates to identity).
    chase_rot  = (chase << 1) | (chase >> (N_LED - 1));
    pwm_on     = (pwm_cnt < level);
  end

  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      level        <= '0;
      led          <= '0;
      busy         <= 1'b0;
      pwm_cnt      <= '0;
      prescaler    <= '0;
      hold_cnt     <= '0;
      gap_len      <= '0;
      gap_cnt      <= '0;
      stop_pending <= 1'b0;
      led_mask     <= '1;
      chase        <= CHASE_FIRST;
    end else begin
      if (prescaler == 8'(PWM_DIV - 1)) begin
        prescaler <= '0;
        pwm_cnt   <= pwm_cnt + 8'd1;
      end else begin
        prescaler <= prescaler + 8'd1;
      end

      led <= (state != IDLE) ? (led_mask & {N_LED{pwm_on}}) : '0;

      if (state != IDLE && stop) stop_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state        <= FADE_UP;
            busy         <= 1'b1;
            level        <= '0;
            stop_pending <= 1'b0;
            chase        <= CHASE_FIRST;
            case (mode)
              2'd1:    led_mask <= rand_mask;
              2'd2:    led_mask <= CHASE_FIRST;
              default: led_mask <= '1;
            endcase
          end
        end
        FADE_UP: begin
          if (tick_play) begin
            level <= up_level;
            if (up_level == 8'hFF) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
        end
        HOLD: begin
          if (tick_play) begin
            hold_cnt <= hold_cnt + 8'd1;
            if (hold_cnt == 8'(HOLD_TICKS - 1)) state <= FADE_DOWN;
          end
        end
        FADE_DOWN: begin
          if (tick_play) begin
            level <= down_level;
            if (down_level == '0) begin
              state   <= GAP;
              gap_len <= {1'b0, rand_num[3:0]} + 5'd1;
              gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          if (tick_play) begin
            gap_cnt <= gap_cnt + 5'd1;
            if (gap_cnt + 5'd1 == gap_len) begin
              // A stop arriving on the final gap tick still ends the pattern.
              if (stop_pending || stop) begin
                state        <= IDLE;
                busy         <= 1'b0;
                level        <= '0;
                stop_pending <= 1'b0;
              end else begin
                state <= FADE_UP;
                case (mode)
                  2'd1: led_mask <= rand_mask;
                  2'd2: begin
                    led_mask <= chase_rot;
                    chase    <= chase_rot;
                  end
                  default: led_mask <= '1;
                endcase
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
